// File: rtl/crane_pkg.sv
// Shared types and constants for the crane core and its memory-side blocks.
// Latency: none, types and constants only.
// Backpressure: none, types and constants only.
package crane_pkg;

  localparam int WORD_W     = 32;
  localparam int STRB_W     = 4;
  localparam int BYTE_W     = 8;
  localparam int REQ_ADDR_W = 32;

  // Responder FSM: accept in IDLE, count wait states in WAIT, hold the answer in RESP
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  // Load/store request as issued by the LSU
  typedef struct packed {
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [WORD_W-1:0]     wdata;
    logic [STRB_W-1:0]     wstrb;
  } mem_req_t;

endpackage

// File: rtl/mem_array.sv
// Word-wide single-port RAM with per-byte write enables, no reset, block-RAM friendly.
// Latency: read data registered, valid the cycle after the enabled read edge.
// Backpressure: none; rdata holds its last read value while the port is idle or writing.
module mem_array
  import crane_pkg::*;
#(
  parameter  int DEPTH_WORDS = 1024,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // One port per edge: a byte-masked write, or a registered read that updates rdata
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < STRB_W; i++) begin
          if (wstrb[i]) begin
            mem[idx][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
          end
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// One-at-a-time load/store responder over a mem_array; MEM_RESP_ERR_EN enables out-of-range errors.
// Latency: response visible LATENCY+1 cycles after the acceptance edge.
// Backpressure: rsp_ready low holds RESP and all outputs; req_ready is low until the response retires.
module mem_responder
  import crane_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WORD_W-1:0]     req_wdata,
  input  logic [STRB_W-1:0]     req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WORD_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  mem_state_e        state_q;
  mem_state_e        state_d;
  logic [3:0]        cnt_q;
  logic [3:0]        cnt_d;
  logic              rsp_zero_q;
  logic              rsp_err_q;
  logic              accept;
  logic              addr_oor;
  logic              ram_en;
  logic [IDX_W-1:0]  word_idx;
  logic [WORD_W-1:0] ram_rdata;
  logic              unused_addr_bits;

  assign accept   = req_valid && (state_q == IDLE);
  assign word_idx = req_addr[2 +: IDX_W];

  // Byte offset always ignored; upper bits only matter when range checking is built in
  assign unused_addr_bits = ^req_addr;

`ifdef MEM_RESP_ERR_EN
  // Any set bit above the word index means the access falls outside the array
  assign addr_oor = (req_addr >> (IDX_W + 2)) != '0;
`else
  // Upper bits dropped: the address space wraps onto the array
  assign addr_oor = 1'b0;
`endif

  // Out-of-range accesses never touch the array, so such writes are discarded
  assign ram_en = accept && !addr_oor;

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_mem_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (req_we),
    .idx   (word_idx),
    .wdata (req_wdata),
    .wstrb (req_wstrb),
    .rdata (ram_rdata)
  );

  // State, wait counter and response qualifiers; qualifiers latch only on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      rsp_zero_q <= 1'b1;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rsp_zero_q <= req_we || addr_oor;
        rsp_err_q  <= addr_oor;
      end
    end
  end

  // Next-state: IDLE accepts, WAIT counts down to zero, RESP waits for the consumer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);

  // Writes, out-of-range reads and the post-reset state present zero read data
  assign rsp_rdata = rsp_zero_q ? '0 : ram_rdata;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  parameter int LAT = 1;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [31:0] mdl [DEPTH];

  mem_responder #(
    .ADDR_WIDTH  (32),
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference memory: word = addr/4, wraps modulo DEPTH unless range errors are built in
  task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] st, output logic [31:0] ed, output logic ee);
    int unsigned word;
    int unsigned idx;
    bit          oor;
    word = addr / 4;
    idx  = word % DEPTH;
    oor  = 1'b0;
`ifdef MEM_RESP_ERR_EN
    oor = (word >= DEPTH);
`endif
    ee = oor;
    ed = (we || oor) ? 32'h0 : mdl[idx];
    if (we && !oor) begin
      for (int b = 0; b < 4; b++) begin
        if (st[b]) mdl[idx][8*b +: 8] = wd[8*b +: 8];
      end
    end
  endtask

  // One request/response; entered and left just after a falling edge
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input int stall, output logic [31:0] got);
    logic [31:0] exp_d;
    logic        exp_e;
    int          g;
    int          lat;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = st;
    rsp_ready = (stall == 0);
    g = 0;
    while (!req_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("req_accept", {31'b0, req_ready}, 32'd1);
    model_access(we, addr, wd, st, exp_d, exp_e);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_latency", lat, LAT);
    chk("rsp_rdata", rsp_rdata, exp_d);
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_e});
    got = rsp_rdata;
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
        chk("stall_rsp_rdata", rsp_rdata, exp_d);
      end
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk("retire_req_ready", {31'b0, req_ready}, 32'd1);
    chk("retire_rsp_valid", {31'b0, rsp_valid}, 32'd0);
  endtask

  // Hold a read valid continuously and measure the acceptance spacing
  task automatic b2b(input logic [31:0] addr, input int n);
    int          acc[$];
    int          g;
    logic [31:0] exp_d;
    logic        exp_e;
    model_access(1'b0, addr, 32'h0, 4'h0, exp_d, exp_e);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = addr;
    req_wstrb = 4'h0;
    g = 0;
    while (acc.size() < n && g < 200) begin
      if (req_ready) acc.push_back(cyc);
      if (rsp_valid) chk("b2b_rdata", rsp_rdata, exp_d);
      @(negedge clk);
      g++;
    end
    req_valid = 1'b0;
    chk("b2b_count", acc.size(), n);
    for (int i = 1; i < acc.size(); i++) chk("b2b_gap", acc[i] - acc[i-1], LAT + 2);
    g = 0;
    while (!req_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("b2b_drain", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    logic [31:0] ed;
    logic        ee;
    logic [31:0] a;
    int          g;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_wstrb = 4'h0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, got);
    chk("wr_rdata_zero", got, 32'h0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, 0, got);
    chk("raw_deadbeef", got, 32'hDEADBEEF);

    xact(1'b1, 32'h20, 32'h00000000, 4'hF, 0, got);
    xact(1'b1, 32'h20, 32'h11223344, 4'b0101, 0, got);
    xact(0, 32'h20, 32'h0, 4'h0, 0, got);
    chk("strobe_merge", got, 32'h00220044);
    xact(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, got);
    xact(1'b0, 32'h23, 32'h0, 4'h0, 0, got);
    chk("zero_strobe", got, 32'h00220044);

    for (int w = 0; w < 16; w++) xact(1'b1, 32'(w * 4), $urandom, 4'hF, 0, got);

    xact(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 0, got);
    xact(1'b1, 32'h1000, 32'h00000055, 4'hF, 0, got);
    xact(1'b0, 32'h0, 32'h0, 4'h0, 0, got);
`ifdef MEM_RESP_ERR_EN
    chk("oor_write_dropped", got, 32'hA5A5A5A5);
`else
    chk("wrap_write_lands", got, 32'h00000055);
`endif
    xact(1'b0, 32'h1000, 32'h0, 4'h0, 0, got);

    xact(1'b0, 32'h10, 32'h0, 4'h0, 10, got);

    b2b(32'h14, 4);

    // Reset during the wait/response phase of an accepted write
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h30;
    req_wdata = 32'hC0FFEE11;
    req_wstrb = 4'hF;
    rsp_ready = 1'b0;
    g = 0;
    while (!req_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    model_access(1'b1, 32'h30, 32'hC0FFEE11, 4'hF, ed, ee);
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_req_ready", {31'b0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midrst_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    xact(1'b0, 32'h30, 32'h0, 4'h0, 0, got);
    chk("midrst_write_kept", got, 32'hC0FFEE11);

    for (int t = 0; t < 40; t++) begin
      a = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 3)) << 12);
      xact(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 2), got);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Single-port word-addressed memory responder that sits on the far end of the core's load/store request bus and answers one request at a time. It accepts requests through a valid/ready handshake, performs the read or byte-masked write, inserts a configurable number of wait states, then returns the response through a second valid/ready handshake. It lets the core be simulated standalone from `tb` and serves as the synthesizable on-chip data RAM.

## Interface
- `ADDR_WIDTH`, 32: byte-address width of `req_addr`.
- `DEPTH_WORDS`, 1024: number of 32-bit words stored; power of two, at least 2.
- `LATENCY`, 1: wait-state cycles between acceptance and response, 0–15.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: the core presents a request.
- `req_ready` output 1: the responder can accept a request.
- `req_we` input 1: 1 = write, 0 = read.
- `req_addr` input ADDR_WIDTH: byte address; bits [1:0] are ignored.
- `req_wdata` input 32: write data.
- `req_wstrb` input 4: byte-lane write enables; bit i enables byte lane i.
- `rsp_valid` output 1: a response is pending.
- `rsp_ready` input 1: the core accepts the response.
- `rsp_rdata` output 32: read data; 0 for writes.
- `rsp_err` output 1: the access is out of range; see Configuration.

## Operation
- FSM states are `IDLE`, `WAIT` and `RESP`. Only one request is outstanding at a time.
- `req_ready` = (state == `IDLE`). A request is accepted on a rising edge where `req_valid && req_ready`.
- On acceptance:
  - The word index is `req_addr[2+:log2(DEPTH_WORDS)]`.
  - A write updates only the strobed bytes at that same edge. `req_wstrb` = 0 writes nothing but still produces a response.
  - A read latches the word into the response register at that same edge. A write loads 0 into the response register.
  - `rsp_err` is computed and latched at that same edge.
- If `LATENCY` = 0, the next state is `RESP`. Otherwise it is `WAIT`, with the counter loaded to `LATENCY`-1.
- `WAIT` decrements the counter each cycle and moves to `RESP` after the cycle in which the counter is 0.
- In `RESP`, `rsp_valid` = 1 and `rsp_rdata`/`rsp_err` are stable. The FSM returns to `IDLE` on the edge where `rsp_ready` = 1.
- `req_valid` is ignored outside `IDLE`. The requester must hold it, and the request is taken once the FSM is back in `IDLE`.
- Read-after-write: a read accepted any cycle after a write's acceptance returns the written data.
- Memory contents are not reset. A read of a never-written word returns X in simulation.

## Timing
- Reset values: `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, FSM in `IDLE`, wait counter 0.
- With acceptance at edge N, `rsp_valid` rises after edge N+`LATENCY`, so it is first visible in cycle N+1+`LATENCY`.
- Minimum request-to-request spacing is `LATENCY`+2 cycles when `rsp_ready` is held at 1.
- `rsp_ready` held at 0 stalls the FSM in `RESP` indefinitely, with all outputs held.
- `rsp_ready` = 1 while `rsp_valid` = 0 has no effect.
- Reset asserted mid-transaction (`WAIT` or `RESP`): the FSM returns to `IDLE` at once and the pending response is dropped. A write already accepted remains committed to memory.

## Configuration
- Controlled by `MEM_RESP_ERR_EN`.
- Defined:
  - An address whose bits above the index range are nonzero is out of range.
  - An out-of-range write updates no memory.
  - An out-of-range read returns 0.
  - Both set `rsp_err` = 1 in `RESP`.
- Undefined:
  - Upper address bits are ignored and addresses wrap modulo `DEPTH_WORDS`*4.
  - `rsp_err` is tied to 0.
- The `rsp_err` port exists in both builds.

## Structure
- Shared package `crane_pkg` holds:
  - the `mem_state_e` enum (`IDLE`, `WAIT`, `RESP`);
  - the `WORD_W` = 32 and `STRB_W` = 4 constants;
  - a `mem_req_t` struct (`we`, `addr`, `wdata`, `wstrb`) reused by the core's LSU.
- Sub-module `mem_array`:
  - `DEPTH_WORDS`×32 storage with per-byte write enables;
  - one synchronous read/write port, no reset;
  - maps to block RAM.

## Test plan
- Reset, then write 0xDEADBEEF to 0x10 with wstrb 4'hF, then read 0x10 → `rsp_rdata` = 0xDEADBEEF, `rsp_err` = 0, `rsp_valid` first visible 2 cycles after the read's acceptance edge (`LATENCY` = 1).
- Write 0x00000000 to 0x20 with 4'hF, then 0x11223344 with wstrb 4'b0101, then read 0x20 → 0x00220044.
- `LATENCY` = 0 and `LATENCY` = 3 builds; `rsp_ready` held at 1, back-to-back reads held valid → requests accepted every 2 cycles and every 5 cycles respectively.
- `rsp_ready` held at 0 for 10 cycles in `RESP` → `rsp_valid`/`rsp_rdata` stable and `req_ready` = 0 throughout. Raise `rsp_ready` → `req_ready` = 1 the next cycle.
- With `MEM_RESP_ERR_EN` and `DEPTH_WORDS` = 1024:
  - write 0x55 to 0x1000 → `rsp_err` = 1;
  - read 0x0000 → prior contents unchanged;
  - read 0x1000 → `rsp_err` = 1, `rsp_rdata` = 0.
  - Without the macro, the same write lands at word 0.
- Pull `rst_n` low during `WAIT` → `rsp_valid` = 0 and `req_ready` = 1 immediately. Release, then read → correct data and normal latency.
